xadc_drp_responder: RTL and testbench

Synthesizable DRP responder that models the XADC side of the DRP/conversion interface for our top-level ADC readout designs.
- Runs a free-running conversion sequencer that captures a 12-bit sample per conversion and pulses eoc_out.
- Serves DRP reads and writes from a small status/config register file.
- Used as the XADC stand-in for simulation and for FPGA loopback builds without the hard macro.

---
 rtl/xadc_drp_pkg.sv | 18 +
 rtl/xadc_drp_responder_conv.sv | 59 +++++
 rtl/xadc_drp_responder.sv | 184 ++++++++++++++++++
 tb/tb_xadc_drp_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_drp_pkg.sv
// Shared constants and types for the XADC DRP responder.
// No logic, so no latency or backpressure.
// Holds the register map, the bus widths and the DRP handshake states.
package xadc_drp_pkg;

    localparam int DADDR_W  = 7;
    localparam int DATA_W   = 16;
    localparam int SAMPLE_W = 12;

    localparam logic [DADDR_W-1:0] ADDR_CFG0 = 7'h40;
    localparam logic [DADDR_W-1:0] ADDR_CFG1 = 7'h41;
    localparam logic [DADDR_W-1:0] ADDR_CFG2 = 7'h42;
    localparam logic [DADDR_W-1:0] ADDR_MAX  = 7'h20;
    localparam logic [DADDR_W-1:0] ADDR_MIN  = 7'h24;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} drp_state_e;

endpackage

// File: rtl/xadc_drp_responder_conv.sv
// Free-running conversion sequencer: timer, channel latch, eoc and busy generation.
// Latency: one result write strobe every CONV_CYCLES clocks; eoc follows the strobe edge.
// Backpressure: none; the sequencer never stalls.
module xadc_conv_seq
    import xadc_drp_pkg::*;
#(
    parameter int CONV_CYCLES = 100
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [4:0] cfg_ch_i,
    output logic       wr_vld_o,
    output logic [4:0] wr_ch_o,
    output logic       eoc_o,
    output logic       busy_o,
    output logic [4:0] channel_o
);

    localparam int TW = $clog2(CONV_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(CONV_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    ch_q;
    logic [4:0]    chan_q;
    logic          eoc_q;
    logic          busy_q;

    always_comb begin
        timer_d = (timer_q == LAST) ? '0 : timer_q + TW'(1);
    end

    // The channel is frozen at timer=0 so mid-conversion CFG0 writes wait for the next one.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timer_q <= '0;
            ch_q    <= '0;
            chan_q  <= '0;
            eoc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            if (timer_q == '0) begin
                ch_q <= cfg_ch_i;
            end
            eoc_q <= wr_vld_o;
            if (wr_vld_o) begin
                chan_q <= ch_q;
            end
            busy_q <= (timer_d != LAST);
        end
    end

    assign wr_vld_o  = (timer_q == LAST);
    assign wr_ch_o   = ch_q;
    assign eoc_o     = eoc_q;
    assign busy_o    = busy_q;
    assign channel_o = chan_q;

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC stand-in: DRP register file plus conversion sequencer; XADC_MINMAX_EN adds running max/min at 0x20/0x24.
// Latency: DRP completes exactly DRDY_LAT cycles after den_in is sampled.
// Backpressure: none; den_in while an access is in flight is dropped and sets sticky err_out.
module xadc_drp_responder
    import xadc_drp_pkg::*;
#(
    parameter int         CONV_CYCLES  = 100,
    parameter int         DRDY_LAT     = 2,
    parameter logic [4:0] INIT_CHANNEL = 5'h16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                den_in,
    input  logic                dwe_in,
    input  logic [DADDR_W-1:0]  daddr_in,
    input  logic [DATA_W-1:0]   di_in,
    output logic [DATA_W-1:0]   do_out,
    output logic                drdy_out,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                eoc_out,
    output logic [4:0]          channel_out,
    output logic                busy_out,
    output logic                err_out
);

    drp_state_e          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DADDR_W-1:0]  addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdat_q;
    logic [DATA_W-1:0]   do_q;
    logic                drdy_q;
    logic                err_q;
    logic [DATA_W-1:0]   cfg0_q, cfg1_q, cfg2_q;
    logic [DATA_W-1:0]   result_q [32];

    logic                ld, ack_go, err_set;
    logic [DADDR_W-1:0]  acc_addr;
    logic                acc_we;
    logic [DATA_W-1:0]   acc_wdat;
    logic [DATA_W-1:0]   rdata;
    logic [DATA_W-1:0]   new_res;
    logic                conv_wr;
    logic [4:0]          conv_ch;

`ifdef XADC_MINMAX_EN
    logic [DATA_W-1:0]   max_q, min_q;
`endif

    assign new_res = {sample_in, 4'b0000};

    xadc_conv_seq #(
        .CONV_CYCLES(CONV_CYCLES)
    ) u_conv (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .cfg_ch_i (cfg0_q[4:0]),
        .wr_vld_o (conv_wr),
        .wr_ch_o  (conv_ch),
        .eoc_o    (eoc_out),
        .busy_o   (busy_out),
        .channel_o(channel_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld      = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (den_in) begin
                    ld = 1'b1;
                    if (DRDY_LAT == 1) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(DRDY_LAT - 1);
                    end
                end
            end
            WAIT: begin
                err_set = den_in;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                err_set = den_in;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ack_go = (state_d == ACK);
    end

    // With DRDY_LAT=1 the access completes on the same edge that would latch it.
    assign acc_addr = (state_q == IDLE) ? daddr_in : addr_q;
    assign acc_we   = (state_q == IDLE) ? dwe_in   : we_q;
    assign acc_wdat = (state_q == IDLE) ? di_in    : wdat_q;

    always_comb begin
        rdata = '0;
        if (acc_addr[6:5] == 2'b00) begin
            rdata = result_q[acc_addr[4:0]];
        end else begin
            case (acc_addr)
                ADDR_CFG0: rdata = cfg0_q;
                ADDR_CFG1: rdata = cfg1_q;
                ADDR_CFG2: rdata = cfg2_q;
`ifdef XADC_MINMAX_EN
                ADDR_MAX:  rdata = max_q;
                ADDR_MIN:  rdata = min_q;
`else
                ADDR_MAX, ADDR_MIN: rdata = '0;
`endif
                default:   rdata = '0;
            endcase
        end
    end

    // Read data is captured from pre-edge state, so a same-edge result update is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            do_q    <= '0;
            drdy_q  <= 1'b0;
            err_q   <= 1'b0;
            cfg0_q  <= {11'b0, INIT_CHANNEL};
            cfg1_q  <= '0;
            cfg2_q  <= '0;
            for (int i = 0; i < 32; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drdy_q  <= ack_go;
            if (ld) begin
                addr_q <= daddr_in;
                we_q   <= dwe_in;
                wdat_q <= di_in;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (ack_go && acc_we) begin
                case (acc_addr)
                    ADDR_CFG0: cfg0_q <= acc_wdat;
                    ADDR_CFG1: cfg1_q <= acc_wdat;
                    ADDR_CFG2: cfg2_q <= acc_wdat;
                    default: ;
                endcase
            end else if (ack_go) begin
                do_q <= rdata;
            end
            if (conv_wr) begin
                result_q[conv_ch] <= new_res;
            end
        end
    end

`ifdef XADC_MINMAX_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q <= 16'h0000;
            min_q <= 16'hFFF0;
        end else if (conv_wr) begin
            if (new_res > max_q) max_q <= new_res;
            if (new_res < min_q) min_q <= new_res;
        end
    end
`endif

    assign do_out   = do_q;
    assign drdy_out = drdy_q;
    assign err_out  = err_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Scoreboarded bench for xadc_drp_responder: expected DRP responses are queued at issue
// and popped by a monitor on every drdy_out; eoc timing and flags are checked directly.
module tb_xadc_drp_responder;

    logic        clk;
    logic        rst_n;
    logic        den_in;
    logic        dwe_in;
    logic [6:0]  daddr_in;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out;
    logic [11:0] sample_in;
    logic        eoc_out;
    logic [4:0]  channel_out;
    logic        busy_out;
    logic        err_out;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q [$];
    logic [6:0]  exp_a [$];
    logic [15:0] exp_last_do;

    xadc_drp_responder #(
        .CONV_CYCLES (100),
        .DRDY_LAT    (2),
        .INIT_CHANNEL(5'h16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .den_in     (den_in),
        .dwe_in     (dwe_in),
        .daddr_in   (daddr_in),
        .di_in      (di_in),
        .do_out     (do_out),
        .drdy_out   (drdy_out),
        .sample_in  (sample_in),
        .eoc_out    (eoc_out),
        .channel_out(channel_out),
        .busy_out   (busy_out),
        .err_out    (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (drdy_out) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_drdy actual=%h required=no_drdy", do_out);
            end else begin
                logic [15:0] e;
                logic [6:0]  a;
                e = exp_q.pop_front();
                a = exp_a.pop_front();
                check($sformatf("drp_addr_%02h", a), do_out, e);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            tick;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drdy_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
            exp_a.delete();
        end
        tick;
    endtask

    task automatic drp_read(input logic [6:0] a, input logic [15:0] e);
        den_in   = 1'b1;
        dwe_in   = 1'b0;
        daddr_in = a;
        exp_q.push_back(e);
        exp_a.push_back(a);
        exp_last_do = e;
        tick;
        den_in = 1'b0;
        drain;
    endtask

    // A write completion leaves do_out at whatever the last read returned.
    task automatic drp_write(input logic [6:0] a, input logic [15:0] d);
        den_in   = 1'b1;
        dwe_in   = 1'b1;
        daddr_in = a;
        di_in    = d;
        exp_q.push_back(exp_last_do);
        exp_a.push_back(a);
        tick;
        den_in = 1'b0;
        dwe_in = 1'b0;
        drain;
    endtask

    task automatic wait_eoc(input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick;
            if (eoc_out) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s actual=no_eoc required=eoc", nm);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int e1, e2, ne;
        rst_n       = 1'b0;
        den_in      = 1'b0;
        dwe_in      = 1'b0;
        daddr_in    = '0;
        di_in       = '0;
        sample_in   = 12'hABC;
        exp_last_do = 16'h0000;
        e1 = -1;
        e2 = -1;
        ne = 0;

        // Reset state and eoc cadence
        repeat (3) tick;
        check("rst_do", do_out, 16'h0000);
        check("rst_flags", {7'b0, channel_out, drdy_out, eoc_out, busy_out, err_out}, 16'h0000);
        rst_n = 1'b1;
        for (int n = 1; n <= 250; n++) begin
            tick;
            if (eoc_out) begin
                ne++;
                if (ne == 1) e1 = n;
                else if (ne == 2) e2 = n;
            end
        end
        check("eoc1_cycle", 16'(e1), 16'd100);
        check("eoc2_cycle", 16'(e2), 16'd200);
        check("eoc_count", 16'(ne), 16'd2);
        check("channel_init", {11'b0, channel_out}, 16'h0016);
        drp_read(7'h16, 16'hABC0);

        // Config registers, read-only results, unmapped space
        drp_write(7'h41, 16'h1234);
        drp_read(7'h41, 16'h1234);
        drp_write(7'h42, 16'hBEEF);
        drp_read(7'h42, 16'hBEEF);
        drp_write(7'h05, 16'hFFFF);
        drp_read(7'h05, 16'h0000);
        drp_write(7'h50, 16'h7777);
        drp_read(7'h50, 16'h0000);
        drp_read(7'h7F, 16'h0000);

        // Read-after-eoc with a ramping source
        for (int i = 0; i < 1024; i++) begin
            if (eoc_out) begin
                exp_q.push_back({sample_in, 4'b0000});
                exp_a.push_back(channel_out);
                exp_last_do = {sample_in, 4'b0000};
            end
            den_in    = eoc_out;
            dwe_in    = 1'b0;
            daddr_in  = channel_out;
            sample_in = 12'(i);
            tick;
        end
        den_in = 1'b0;
        drain;

        // CFG0 change mid-conversion
        wait_eoc("eoc_sync");
        repeat (30) tick;
        drp_write(7'h40, 16'h0010);
        sample_in = 12'h5A5;
        wait_eoc("eoc_old_ch");
        check("channel_before_switch", {11'b0, channel_out}, 16'h0016);
        wait_eoc("eoc_new_ch");
        check("channel_after_switch", {11'b0, channel_out}, 16'h0010);
        drp_read(7'h10, 16'h5A50);
        drp_read(7'h40, 16'h0010);

        // Two-cycle den: one response, sticky error
        check("err_clear", {15'b0, err_out}, 16'h0000);
        den_in   = 1'b1;
        dwe_in   = 1'b0;
        daddr_in = 7'h40;
        exp_q.push_back(16'h0010);
        exp_a.push_back(7'h40);
        exp_last_do = 16'h0010;
        tick;
        tick;
        den_in = 1'b0;
        drain;
        check("err_set", {15'b0, err_out}, 16'h0001);
        repeat (10) tick;
        check("err_sticky", {15'b0, err_out}, 16'h0001);

        // Reset while a read is in WAIT
        den_in   = 1'b1;
        daddr_in = 7'h40;
        tick;
        den_in = 1'b0;
        rst_n  = 1'b0;
        tick;
        exp_last_do = 16'h0000;
        check("rst_wait_do", do_out, 16'h0000);
        check("rst_wait_flags", {7'b0, channel_out, drdy_out, eoc_out, busy_out, err_out}, 16'h0000);
        tick;
        rst_n = 1'b1;
        repeat (4) tick;
        drp_read(7'h40, 16'h0016);
        drp_read(7'h16, 16'h0000);

        // Running max/min
        sample_in = 12'h100;
        wait_eoc("eoc_mm1");
        sample_in = 12'h050;
        wait_eoc("eoc_mm2");
        sample_in = 12'h200;
        wait_eoc("eoc_mm3");
`ifdef XADC_MINMAX_EN
        drp_read(7'h20, 16'h2000);
        drp_read(7'h24, 16'h0500);
`else
        drp_read(7'h20, 16'h0000);
        drp_read(7'h24, 16'h0000);
`endif
        drp_read(7'h16, 16'h2000);

        repeat (5) tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
